// File: rtl/hazard_unit_if.sv
// Decode-stage hazard control bundle: pipeline-side signals into the hazard unit
// and the stall/flush/scoreboard controls coming back out.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_issue_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_uses_rs1_i;
    logic             id_uses_rs2_i;
    logic [4:0]       id_rd_i;
    logic             id_is_load_i;
    logic             wb_valid_i;
    logic [4:0]       wb_rd_i;
    logic             branch_taken_i;
    logic             dmem_stall_i;

    logic             stall_if_o;
    logic             stall_id_o;
    logic             bubble_ex_o;
    logic             freeze_o;
    logic             flush_if_o;
    logic             flush_id_o;
    logic [31:0]      busy_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             hang_o;

    modport master (
        output id_issue_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
               id_rd_i, id_is_load_i, wb_valid_i, wb_rd_i, branch_taken_i,
               dmem_stall_i,
        input  stall_if_o, stall_id_o, bubble_ex_o, freeze_o, flush_if_o,
               flush_id_o, busy_o, stall_cnt_o, hang_o
    );

    modport slave (
        input  id_issue_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
               id_rd_i, id_is_load_i, wb_valid_i, wb_rd_i, branch_taken_i,
               dmem_stall_i,
        output stall_if_o, stall_id_o, bubble_ex_o, freeze_o, flush_if_o,
               flush_id_o, busy_o, stall_cnt_o, hang_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard detection with an in-flight load scoreboard, stall/flush
// priority resolution, a saturating stall counter and a stuck-stall watchdog.
module hazard_unit #(
    parameter int CNT_W      = 16,
    parameter int HANG_LIMIT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    hazard_unit_if.slave hz
);
    localparam int RUN_W = $clog2(HANG_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(HANG_LIMIT);

    logic [31:0]      busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             hang;

    logic        haz_rs1;
    logic        haz_rs2;
    logic        lu;
    logic        lu_stall;
    logic        advance;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_LIMIT) ? v : v + 1'b1;
    endfunction

    // A writeback landing this cycle is bypassed to ID, so it never causes a stall.
    always_comb begin
        haz_rs1 = hz.id_issue_i & hz.id_uses_rs1_i & (hz.id_rs1_i != 5'd0)
                & busy[hz.id_rs1_i]
                & ~(hz.wb_valid_i & (hz.wb_rd_i == hz.id_rs1_i));
        haz_rs2 = hz.id_issue_i & hz.id_uses_rs2_i & (hz.id_rs2_i != 5'd0)
                & busy[hz.id_rs2_i]
                & ~(hz.wb_valid_i & (hz.wb_rd_i == hz.id_rs2_i));
        lu       = haz_rs1 | haz_rs2;
        lu_stall = lu & ~hz.dmem_stall_i & ~hz.branch_taken_i;
        advance  = hz.id_issue_i & ~hz.dmem_stall_i & ~hz.branch_taken_i & ~lu;
    end

    always_comb begin
        hz.stall_if_o  = 1'b0;
        hz.stall_id_o  = 1'b0;
        hz.bubble_ex_o = 1'b0;
        hz.freeze_o    = 1'b0;
        hz.flush_if_o  = 1'b0;
        hz.flush_id_o  = 1'b0;
        if (hz.dmem_stall_i) begin
            hz.stall_if_o = 1'b1;
            hz.stall_id_o = 1'b1;
            hz.freeze_o   = 1'b1;
        end else if (hz.branch_taken_i) begin
            hz.flush_if_o = 1'b1;
            hz.flush_id_o = 1'b1;
        end else if (lu) begin
            hz.stall_if_o  = 1'b1;
            hz.stall_id_o  = 1'b1;
            hz.bubble_ex_o = 1'b1;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (advance && hz.id_is_load_i && (hz.id_rd_i != 5'd0))
            set_mask = 32'd1 << hz.id_rd_i;
        if (hz.wb_valid_i && (hz.wb_rd_i != 5'd0))
            clr_mask = 32'd1 << hz.wb_rd_i;
    end

    // Set is applied after clear so a newer load to the same register stays pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
            hang      <= 1'b0;
        end else begin
            if (lu_stall) begin
                stall_cnt <= cnt_sat_inc(stall_cnt);
                run_cnt   <= run_sat_inc(run_cnt);
                if (run_sat_inc(run_cnt) == RUN_LIMIT)
                    hang <= 1'b1;
            end else if (!hz.dmem_stall_i) begin
                run_cnt <= '0;
            end
        end
    end

    assign hz.busy_o      = busy;
    assign hz.stall_cnt_o = stall_cnt;
    assign hz.hang_o      = hang;
endmodule
